// File: rtl/id_ex_stage_if.sv
// ID -> EX boundary bundle for id_ex_stage: ID operands/control in, EX operands/control out.
// The write-back bypass signals exist only when ID_EX_WB_BYPASS_EN is defined.
interface id_ex_stage_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic                  stall;
  logic                  flush;
  logic [5:0]            id_opcode;
  logic [5:0]            id_funct;
  logic [4:0]            id_shamt;
  logic [15:0]           id_imm;
  logic [REG_ADDR_W-1:0] id_rs_addr;
  logic [REG_ADDR_W-1:0] id_rt_addr;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic [WIDTH-1:0]      id_rs_data;
  logic [WIDTH-1:0]      id_rt_data;
`ifdef ID_EX_WB_BYPASS_EN
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]      wb_data;
`endif

  logic                  ex_valid;
  logic [WIDTH-1:0]      ex_dataA;
  logic [WIDTH-1:0]      ex_dataB;
  logic [2:0]            ex_signal;
  logic [WIDTH-1:0]      ex_store_data;
  logic [REG_ADDR_W-1:0] ex_wr_addr;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_mem_to_reg;
  logic                  ex_branch;
  logic                  ex_illegal;

  // The ID stage (or a bench) is the master; the pipeline register is the slave.
  modport master (
    output id_valid, stall, flush, id_opcode, id_funct, id_shamt, id_imm,
           id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
`ifdef ID_EX_WB_BYPASS_EN
    output wb_we, wb_addr, wb_data,
`endif
    input  ex_valid, ex_dataA, ex_dataB, ex_signal, ex_store_data, ex_wr_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal
  );

  modport slave (
    input  id_valid, stall, flush, id_opcode, id_funct, id_shamt, id_imm,
           id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
`ifdef ID_EX_WB_BYPASS_EN
    input  wb_we, wb_addr, wb_data,
`endif
    output ex_valid, ex_dataA, ex_dataB, ex_signal, ex_store_data, ex_wr_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, stall hold and flush bubble.
// Optional same-cycle write-back bypass on the operands: define ID_EX_WB_BYPASS_EN.
module id_ex_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic            clk,
  input logic            rst,
  id_ex_stage_if.slave   bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLL = 3'b011,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluSignal_e;

  typedef struct packed {
    logic                  valid;
    logic [WIDTH-1:0]      dataA;
    logic [WIDTH-1:0]      dataB;
    logic [2:0]            signal;
    logic [WIDTH-1:0]      storeData;
    logic [REG_ADDR_W-1:0] wrAddr;
    logic                  regWrite;
    logic                  memRead;
    logic                  memWrite;
    logic                  memToReg;
    logic                  branch;
    logic                  illegal;
  } exSlot_t;

  exSlot_t          decoded;
  exSlot_t          slot_d;
  exSlot_t          slot_q;
  logic [WIDTH-1:0] rsOperand;
  logic [WIDTH-1:0] rtOperand;
  logic [WIDTH-1:0] immSext;
  logic [WIDTH-1:0] shamtZext;

  assign immSext   = {{(WIDTH-16){bus.id_imm[15]}}, bus.id_imm};
  assign shamtZext = {{(WIDTH-5){1'b0}}, bus.id_shamt};

  // Operand fetch; a register being written back this cycle wins over the stale file value.
  always_comb begin
    rsOperand = bus.id_rs_data;
    rtOperand = bus.id_rt_data;
`ifdef ID_EX_WB_BYPASS_EN
    if (bus.wb_we && (bus.wb_addr != '0) && (bus.wb_addr == bus.id_rs_addr))
      rsOperand = bus.wb_data;
    if (bus.wb_we && (bus.wb_addr != '0) && (bus.wb_addr == bus.id_rt_addr))
      rtOperand = bus.wb_data;
`endif
  end

  // Instruction decode; anything unrecognised becomes a bubble tagged illegal.
  always_comb begin
    decoded = '0;
    unique case (bus.id_opcode)
      OP_RTYPE: begin
        decoded.valid    = 1'b1;
        decoded.dataA    = rsOperand;
        decoded.dataB    = rtOperand;
        decoded.wrAddr   = bus.id_rd_addr;
        decoded.regWrite = 1'b1;
        unique case (bus.id_funct)
          FN_AND: decoded.signal = ALU_AND;
          FN_OR:  decoded.signal = ALU_OR;
          FN_ADD: decoded.signal = ALU_ADD;
          FN_SUB: decoded.signal = ALU_SUB;
          FN_SLT: decoded.signal = ALU_SLT;
          FN_SLL: begin
            decoded.signal = ALU_SLL;
            decoded.dataA  = rtOperand;
            decoded.dataB  = shamtZext;
          end
          default: begin
            decoded         = '0;
            decoded.illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        decoded.valid     = 1'b1;
        decoded.signal    = ALU_ADD;
        decoded.dataA     = rsOperand;
        decoded.dataB     = immSext;
        decoded.storeData = rtOperand;
        decoded.wrAddr    = bus.id_rt_addr;
        decoded.regWrite  = 1'b1;
        decoded.memRead   = 1'b1;
        decoded.memToReg  = 1'b1;
      end
      OP_SW: begin
        decoded.valid     = 1'b1;
        decoded.signal    = ALU_ADD;
        decoded.dataA     = rsOperand;
        decoded.dataB     = immSext;
        decoded.storeData = rtOperand;
        decoded.memWrite  = 1'b1;
      end
      OP_BEQ: begin
        decoded.valid     = 1'b1;
        decoded.signal    = ALU_SUB;
        decoded.dataA     = rsOperand;
        decoded.dataB     = rtOperand;
        decoded.storeData = rtOperand;
        decoded.branch    = 1'b1;
      end
      OP_J: decoded.valid = 1'b1;
      default: decoded.illegal = 1'b1;
    endcase
    // $zero is never written, but the index is still carried downstream.
    if (decoded.wrAddr == '0)
      decoded.regWrite = 1'b0;
  end

  always_comb begin
    slot_d = '0;
    if (bus.flush)
      slot_d = '0;
    else if (bus.stall)
      slot_d = slot_q;
    else if (bus.id_valid)
      slot_d = decoded;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      slot_q <= '0;
    else
      slot_q <= slot_d;
  end

  assign bus.ex_valid      = slot_q.valid;
  assign bus.ex_dataA      = slot_q.dataA;
  assign bus.ex_dataB      = slot_q.dataB;
  assign bus.ex_signal     = slot_q.signal;
  assign bus.ex_store_data = slot_q.storeData;
  assign bus.ex_wr_addr    = slot_q.wrAddr;
  assign bus.ex_reg_write  = slot_q.regWrite;
  assign bus.ex_mem_read   = slot_q.memRead;
  assign bus.ex_mem_write  = slot_q.memWrite;
  assign bus.ex_mem_to_reg = slot_q.memToReg;
  assign bus.ex_branch     = slot_q.branch;
  assign bus.ex_illegal    = slot_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random instructions against a reference model.
// Bypass stimulus and expectations are included when ID_EX_WB_BYPASS_EN is defined.
module tb_id_ex_stage;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  id_ex_stage_if #(.WIDTH(32), .REG_ADDR_W(5)) bus ();

  id_ex_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sig;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        br;
    logic        ill;
  } expect_t;

  expect_t expState;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string where);
    checkOutput({where, ".valid"}, 32'(bus.ex_valid),      32'(expState.valid));
    checkOutput({where, ".dataA"}, bus.ex_dataA,           expState.a);
    checkOutput({where, ".dataB"}, bus.ex_dataB,           expState.b);
    checkOutput({where, ".signal"}, 32'(bus.ex_signal),    32'(expState.sig));
    checkOutput({where, ".store"}, bus.ex_store_data,      expState.sd);
    checkOutput({where, ".wr"},    32'(bus.ex_wr_addr),    32'(expState.wr));
    checkOutput({where, ".rw"},    32'(bus.ex_reg_write),  32'(expState.rw));
    checkOutput({where, ".mr"},    32'(bus.ex_mem_read),   32'(expState.mr));
    checkOutput({where, ".mw"},    32'(bus.ex_mem_write),  32'(expState.mw));
    checkOutput({where, ".m2r"},   32'(bus.ex_mem_to_reg), 32'(expState.m2r));
    checkOutput({where, ".br"},    32'(bus.ex_branch),     32'(expState.br));
    checkOutput({where, ".ill"},   32'(bus.ex_illegal),    32'(expState.ill));
  endtask

  // Reference behaviour: what the EX slot should hold after the coming edge.
  function automatic expect_t predict(input expect_t current);
    expect_t     e;
    logic [31:0] rsV;
    logic [31:0] rtV;
    int          aluCode;
    e   = '0;
    rsV = bus.id_rs_data;
    rtV = bus.id_rt_data;
`ifdef ID_EX_WB_BYPASS_EN
    if (bus.wb_we && bus.wb_addr != 0 && bus.wb_addr == bus.id_rs_addr) rsV = bus.wb_data;
    if (bus.wb_we && bus.wb_addr != 0 && bus.wb_addr == bus.id_rt_addr) rtV = bus.wb_data;
`endif
    if (bus.flush) return '0;
    if (bus.stall) return current;
    if (!bus.id_valid) return '0;
    aluCode = -1;
    if (bus.id_opcode == 6'h00) begin
      case (bus.id_funct)
        6'h24: aluCode = 0;
        6'h25: aluCode = 1;
        6'h20: aluCode = 2;
        6'h22: aluCode = 6;
        6'h2A: aluCode = 7;
        6'h00: aluCode = 3;
        default: aluCode = -1;
      endcase
      if (aluCode < 0) begin
        e.ill = 1'b1;
        return e;
      end
      e.valid = 1'b1;
      e.sig   = 3'(aluCode);
      e.a     = (aluCode == 3) ? rtV : rsV;
      e.b     = (aluCode == 3) ? 32'(bus.id_shamt) : rtV;
      e.wr    = bus.id_rd_addr;
      e.rw    = (bus.id_rd_addr != 0);
    end else if (bus.id_opcode == 6'h23 || bus.id_opcode == 6'h2B) begin
      e.valid = 1'b1;
      e.sig   = 3'd2;
      e.a     = rsV;
      e.b     = 32'($signed(bus.id_imm));
      e.sd    = rtV;
      if (bus.id_opcode == 6'h23) begin
        e.wr  = bus.id_rt_addr;
        e.rw  = (bus.id_rt_addr != 0);
        e.mr  = 1'b1;
        e.m2r = 1'b1;
      end else begin
        e.mw  = 1'b1;
      end
    end else if (bus.id_opcode == 6'h04) begin
      e.valid = 1'b1;
      e.sig   = 3'd6;
      e.a     = rsV;
      e.b     = rtV;
      e.sd    = rtV;
      e.br    = 1'b1;
    end else if (bus.id_opcode == 6'h02) begin
      e.valid = 1'b1;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic driveInstr(input logic valid, input logic [5:0] op, input logic [5:0] fn,
                            input logic [4:0] sh, input logic [15:0] imm,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rsD, input logic [31:0] rtD);
    bus.id_valid   = valid;
    bus.id_opcode  = op;
    bus.id_funct   = fn;
    bus.id_shamt   = sh;
    bus.id_imm     = imm;
    bus.id_rs_addr = rs;
    bus.id_rt_addr = rt;
    bus.id_rd_addr = rd;
    bus.id_rs_data = rsD;
    bus.id_rt_data = rtD;
  endtask

  // One clock: set stall/flush, advance the model, check every output just after the edge.
  task automatic applyStimulus(input logic st, input logic fl, input string where);
    expect_t nxt;
    bus.stall = st;
    bus.flush = fl;
    nxt = predict(expState);
    @(posedge clk);
    expState = nxt;
    #1;
    checkAll(where);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    expState = '0;
    rst      = 1'b1;
    driveInstr(1'b0, 6'h00, 6'h00, 5'd0, 16'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
`ifdef ID_EX_WB_BYPASS_EN
    bus.wb_we   = 1'b0;
    bus.wb_addr = 5'd0;
    bus.wb_data = 32'h0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    rst = 1'b0;

    // ADD rs=3 rt=15 rd=4
    driveInstr(1'b1, 6'h00, 6'h20, 5'd0, 16'h0, 5'd1, 5'd2, 5'd4, 32'd3, 32'd15);
    applyStimulus(1'b0, 1'b0, "add");
    checkOutput("add.A.const", bus.ex_dataA, 32'd3);
    checkOutput("add.rw.const", 32'(bus.ex_reg_write), 32'd1);

    // lw with negative offset
    driveInstr(1'b1, 6'h23, 6'h00, 5'd0, 16'hFFFC, 5'd1, 5'd8, 5'd0, 32'h10, 32'h5);
    applyStimulus(1'b0, 1'b0, "lw");
    checkOutput("lw.B.const", bus.ex_dataB, 32'hFFFF_FFFC);
    checkOutput("lw.wr.const", 32'(bus.ex_wr_addr), 32'd8);

    driveInstr(1'b1, 6'h00, 6'h00, 5'd4, 16'h0, 5'd0, 5'd2, 5'd9, 32'h77, 32'd3);
    applyStimulus(1'b0, 1'b0, "sll");
    checkOutput("sll.sig.const", 32'(bus.ex_signal), 32'd3);
    driveInstr(1'b1, 6'h00, 6'h2A, 5'd0, 16'h0, 5'd1, 5'd2, 5'd3, 32'd3, 32'd8);
    applyStimulus(1'b0, 1'b0, "slt");
    checkOutput("slt.sig.const", 32'(bus.ex_signal), 32'd7);

    // SUB then stall with fresh ID data, then stall+flush
    driveInstr(1'b1, 6'h00, 6'h22, 5'd0, 16'h0, 5'd1, 5'd2, 5'd6, 32'd50, 32'd20);
    applyStimulus(1'b0, 1'b0, "sub");
    driveInstr(1'b1, 6'h00, 6'h25, 5'd0, 16'h0, 5'd3, 5'd4, 5'd7, 32'd1, 32'd2);
    applyStimulus(1'b1, 1'b0, "stall1");
    applyStimulus(1'b1, 1'b0, "stall2");
    checkOutput("stall.sig.const", 32'(bus.ex_signal), 32'd6);
    applyStimulus(1'b1, 1'b1, "stallflush");

    // Asynchronous reset between edges
    driveInstr(1'b1, 6'h2B, 6'h00, 5'd0, 16'h0004, 5'd1, 5'd2, 5'd0, 32'h100, 32'hCAFE);
    applyStimulus(1'b0, 1'b0, "sw");
    #2 rst = 1'b1;
    #1;
    expState = '0;
    checkAll("asyncrst");
    #1 rst = 1'b0;

    driveInstr(1'b1, 6'h3F, 6'h00, 5'd0, 16'h0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
    applyStimulus(1'b0, 1'b0, "illegal");
    checkOutput("illegal.const", 32'(bus.ex_illegal), 32'd1);
    driveInstr(1'b0, 6'h00, 6'h20, 5'd0, 16'h0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
    applyStimulus(1'b0, 1'b0, "illegalclear");

    driveInstr(1'b1, 6'h00, 6'h20, 5'd0, 16'h0, 5'd1, 5'd2, 5'd0, 32'h9, 32'h9);
    applyStimulus(1'b0, 1'b0, "rd0");
    checkOutput("rd0.rw.const", 32'(bus.ex_reg_write), 32'd0);

`ifdef ID_EX_WB_BYPASS_EN
    bus.wb_we   = 1'b1;
    bus.wb_addr = 5'd5;
    bus.wb_data = 32'hAA;
    driveInstr(1'b1, 6'h00, 6'h20, 5'd0, 16'h0, 5'd5, 5'd2, 5'd3, 32'h11, 32'h22);
    applyStimulus(1'b0, 1'b0, "bypass");
    checkOutput("bypass.A.const", bus.ex_dataA, 32'hAA);
`endif

    // Random instruction mix, small register indices so $zero and bypass hits recur
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int         kind;
      logic [5:0] fnTable [6];
      fnTable = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h00};
      kind = int'($urandom_range(0, 9));
      fn   = fnTable[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
      case (kind)
        0, 1, 2, 3, 4: op = 6'h00;
        5:       op = 6'h23;
        6:       op = 6'h2B;
        7:       op = 6'h04;
        8:       op = 6'h02;
        default: op = 6'($urandom);
      endcase
      driveInstr(($urandom_range(0, 7) != 0), op, fn, 5'($urandom), 16'($urandom),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom, $urandom);
`ifdef ID_EX_WB_BYPASS_EN
      bus.wb_we   = 1'($urandom);
      bus.wb_addr = 5'($urandom_range(0, 7));
      bus.wb_data = $urandom;
`endif
      applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
